// File: rtl/vga_sync_generator.sv
// VGA sync timing generator: pixel-enable strobe from the system clock, h/v counters,
// and registered sync/blank/frame-start outputs decoded from the next counter state.
module vga_sync_generator #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk_100MHZ,
    input  logic       reset,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);

    logic [DIV_W-1:0] divider;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             wrap_frame;

    always_comb begin
        div_nxt    = (divider == DIV_LAST) ? '0 : divider + 1'b1;
        h_nxt      = h_count;
        v_nxt      = v_count;
        wrap_frame = 1'b0;
        if (pix_tick) begin
            if (h_count == H_LAST) begin
                h_nxt = '0;
                if (v_count == V_LAST) begin
                    v_nxt      = '0;
                    wrap_frame = 1'b1;
                end else begin
                    v_nxt = v_count + 10'd1;
                end
            end else begin
                h_nxt = h_count + 10'd1;
            end
        end
    end

    // Decodes use the next-state counters so they line up with h_count/v_count without skew.
    always_ff @(posedge clk_100MHZ) begin
        if (reset) begin
            divider     <= '0;
            pix_tick    <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            video_on    <= 1'b1;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            frame_start <= 1'b0;
        end else begin
            divider     <= div_nxt;
            pix_tick    <= (div_nxt == DIV_LAST);
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            hsync       <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
            vsync       <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
            frame_start <= wrap_frame;
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench for vga_sync_generator: default 640x480 timing over a couple of lines,
// plus a tiny override instance exercised over whole frames.
`timescale 1ns/1ps
module tb_vga_sync_generator;

    logic       clk_100MHZ = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;

    logic       a_pt, a_hs, a_vs, a_vid, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_pt, b_hs, b_vs, b_vid, b_fs;
    logic [9:0] b_h, b_v;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned a_clk = 0;

    always #5 clk_100MHZ = ~clk_100MHZ;

    vga_sync_generator dut_a (
        .clk_100MHZ (clk_100MHZ),
        .reset      (rst_a),
        .pix_tick   (a_pt),
        .hsync      (a_hs),
        .vsync      (a_vs),
        .video_on   (a_vid),
        .h_count    (a_h),
        .v_count    (a_v),
        .frame_start(a_fs)
    );

    vga_sync_generator #(
        .CLK_DIV (2),
        .H_ACTIVE(8),
        .H_FP    (2),
        .H_SYNC  (3),
        .H_BP    (1),
        .V_ACTIVE(4),
        .V_FP    (1),
        .V_SYNC  (1),
        .V_BP    (1),
        .SYNC_POL(1)
    ) dut_b (
        .clk_100MHZ (clk_100MHZ),
        .reset      (rst_b),
        .pix_tick   (b_pt),
        .hsync      (b_hs),
        .vsync      (b_vs),
        .video_on   (b_vid),
        .h_count    (b_h),
        .v_count    (b_v),
        .frame_start(b_fs)
    );

    task automatic clk1();
        @(posedge clk_100MHZ);
        #1;
    endtask

    task automatic test_reset();
        logic       exp_pt;
        logic [9:0] exp_h;
        rst_a = 1'b1;
        repeat (5) clk1();
        vectors++;
        if ({a_h, a_v, a_vid, a_hs, a_vs, a_fs, a_pt} !== {10'd0, 10'd0, 5'b11100}) begin
            miscompares++;
            $display("FAIL reset_state: h=%0d v=%0d vid=%b hs=%b vs=%b fs=%b pt=%b, want 0 0 1 1 1 0 0",
                     a_h, a_v, a_vid, a_hs, a_vs, a_fs, a_pt);
        end
        rst_a = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            clk1();
            exp_pt = (c % 4 == 3);
            exp_h  = 10'(c / 4);
            vectors++;
            if ({a_pt, a_h, a_v, a_fs} !== {exp_pt, exp_h, 10'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL release_tick clk=%0d: pt=%b h=%0d v=%0d fs=%b, want pt=%b h=%0d v=0 fs=0",
                         c, a_pt, a_h, a_v, a_fs, exp_pt, exp_h);
            end
        end
        a_clk = 12;
    endtask

    task automatic test_line();
        int unsigned t, hs_low, wrap_clk;
        logic [9:0]  eh, ev, fall_h;
        logic        evid, ehs, ept, prev_vid;
        hs_low   = 0;
        wrap_clk = 0;
        fall_h   = 10'h3ff;
        prev_vid = a_vid;
        while (a_clk < 3204) begin
            clk1();
            a_clk++;
            t    = a_clk / 4;
            eh   = 10'(t % 800);
            ev   = 10'(t / 800);
            evid = (eh < 10'd640) && (ev < 10'd480);
            ehs  = !(eh >= 10'd656 && eh <= 10'd751);
            ept  = (a_clk % 4 == 3);
            vectors++;
            if ({a_h, a_v, a_vid, a_hs, a_vs, a_pt, a_fs} !== {eh, ev, evid, ehs, 1'b1, ept, 1'b0}) begin
                miscompares++;
                $display("FAIL line clk=%0d: h=%0d v=%0d vid=%b hs=%b vs=%b pt=%b fs=%b, want %0d %0d %b %b 1 %b 0",
                         a_clk, a_h, a_v, a_vid, a_hs, a_vs, a_pt, a_fs, eh, ev, evid, ehs, ept);
            end
            if (a_clk <= 3200 && a_hs == 1'b0) hs_low++;
            if (prev_vid && !a_vid && fall_h == 10'h3ff) fall_h = a_h;
            if (a_h == 10'd0 && a_v == 10'd1 && wrap_clk == 0) wrap_clk = a_clk;
            prev_vid = a_vid;
        end
        vectors++;
        if (hs_low != 384) begin
            miscompares++;
            $display("FAIL hsync_width: %0d clocks low, want 384", hs_low);
        end
        vectors++;
        if (fall_h != 10'd640) begin
            miscompares++;
            $display("FAIL video_off_column: fell at h=%0d, want 640", fall_h);
        end
        vectors++;
        if (wrap_clk != 3200) begin
            miscompares++;
            $display("FAIL line_length: wrap at clock %0d, want 3200", wrap_clk);
        end
    endtask

    // Mid-line reset on line 1; reaching line 300 at the default rate would dominate run time.
    task automatic test_mid_reset();
        bit         found;
        logic       exp_pt;
        logic [9:0] exp_h;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            clk1();
            if (a_h == 10'd700) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_reset_reach: h=%0d v=%0d, want h=700 within 4000 clocks", a_h, a_v);
        end
        rst_a = 1'b1;
        clk1();
        vectors++;
        if ({a_h, a_v, a_vid, a_hs, a_vs, a_fs, a_pt} !== {10'd0, 10'd0, 5'b11100}) begin
            miscompares++;
            $display("FAIL mid_reset_state: h=%0d v=%0d vid=%b hs=%b vs=%b fs=%b pt=%b, want 0 0 1 1 1 0 0",
                     a_h, a_v, a_vid, a_hs, a_vs, a_fs, a_pt);
        end
        rst_a = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            clk1();
            exp_pt = (c % 4 == 3);
            exp_h  = 10'(c / 4);
            vectors++;
            if ({a_pt, a_h, a_v, a_hs} !== {exp_pt, exp_h, 10'd0, 1'b1}) begin
                miscompares++;
                $display("FAIL restart_tick clk=%0d: pt=%b h=%0d v=%0d hs=%b, want pt=%b h=%0d v=0 hs=1",
                         c, a_pt, a_h, a_v, a_hs, exp_pt, exp_h);
            end
        end
    endtask

    task automatic test_small_frame();
        int unsigned t, vs_clks, fs1, fs2;
        logic [9:0]  eh, ev;
        logic        evid, ehs, evs, ept, efs;
        vs_clks = 0;
        fs1     = 0;
        fs2     = 0;
        rst_b   = 1'b1;
        repeat (3) clk1();
        vectors++;
        if ({b_h, b_v, b_vid, b_hs, b_vs, b_fs, b_pt} !== {10'd0, 10'd0, 5'b10000}) begin
            miscompares++;
            $display("FAIL small_reset_state: h=%0d v=%0d vid=%b hs=%b vs=%b fs=%b pt=%b, want 0 0 1 0 0 0 0",
                     b_h, b_v, b_vid, b_hs, b_vs, b_fs, b_pt);
        end
        rst_b = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            clk1();
            t    = c / 2;
            eh   = 10'(t % 14);
            ev   = 10'((t / 14) % 7);
            evid = (eh < 10'd8) && (ev < 10'd4);
            ehs  = (eh >= 10'd10 && eh <= 10'd12);
            evs  = (ev == 10'd5);
            ept  = (c % 2 == 1);
            efs  = (c % 196 == 0);
            vectors++;
            if ({b_h, b_v, b_vid, b_hs, b_vs, b_pt, b_fs} !== {eh, ev, evid, ehs, evs, ept, efs}) begin
                miscompares++;
                $display("FAIL small_frame clk=%0d: h=%0d v=%0d vid=%b hs=%b vs=%b pt=%b fs=%b, want %0d %0d %b %b %b %b %b",
                         c, b_h, b_v, b_vid, b_hs, b_vs, b_pt, b_fs, eh, ev, evid, ehs, evs, ept, efs);
            end
            if (c <= 196 && b_vs) vs_clks++;
            if (b_fs && fs1 == 0) fs1 = c;
            else if (b_fs && fs2 == 0) fs2 = c;
        end
        vectors++;
        if (vs_clks != 28) begin
            miscompares++;
            $display("FAIL small_vsync_width: %0d clocks, want 28", vs_clks);
        end
        vectors++;
        if (fs1 != 196 || fs2 - fs1 != 196) begin
            miscompares++;
            $display("FAIL small_frame_period: first=%0d second=%0d, want 196 and 392", fs1, fs2);
        end
    endtask

    task automatic test_small_mid_reset();
        bit          found;
        int unsigned fs1;
        found = 1'b0;
        fs1   = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            clk1();
            if (b_v == 10'd3 && b_h == 10'd5) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL small_mid_reach: h=%0d v=%0d, want (5,3) within 300 clocks", b_h, b_v);
        end
        rst_b = 1'b1;
        clk1();
        vectors++;
        if ({b_h, b_v, b_vid, b_hs, b_vs, b_fs, b_pt} !== {10'd0, 10'd0, 5'b10000}) begin
            miscompares++;
            $display("FAIL small_mid_state: h=%0d v=%0d vid=%b hs=%b vs=%b fs=%b pt=%b, want 0 0 1 0 0 0 0",
                     b_h, b_v, b_vid, b_hs, b_vs, b_fs, b_pt);
        end
        rst_b = 1'b0;
        for (int c = 1; c <= 200 && fs1 == 0; c++) begin
            clk1();
            if (b_fs) fs1 = c;
        end
        vectors++;
        if (fs1 != 196) begin
            miscompares++;
            $display("FAIL small_restart_period: frame_start at clock %0d, want 196", fs1);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_mid_reset();
        test_small_frame();
        test_small_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
